// File: rtl/fir_out_requant.sv
// ============================================================================
// fir_out_requant
// ----------------------------------------------------------------------------
// Purpose:
//   Output-side companion to the FIR filter. Requantizes the 32-bit signed
//   filter result to 16-bit samples: arithmetic right shift by SHIFT, optional
//   round-half-up, and saturation to the int16 range. After every LP/HP mode
//   switch, SETTLE transient samples are discarded. Accepted samples are
//   queued in a DEPTH-entry FIFO with a ready/valid output.
//
// Build option:
//   FIR_REQ_ROUND_EN  defined   -> round-half-up (add 1<<(SHIFT-1) before shift)
//                     undefined -> truncation (floor via arithmetic shift)
//
// Parameters:
//   SHIFT   right-shift amount, 1..16
//   DEPTH   FIFO entries, power of 2, >= 2
//   SETTLE  samples discarded after a mode change (0 = never discard)
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   mode        filter mode (0 = LP, 1 = HP)
//   y_in        signed 32-bit filter output
//   y_valid     y_in valid this cycle
//   sample_out  signed 16-bit sample at FIFO head (holds last value when empty)
//   out_valid   FIFO not empty
//   out_ready   downstream accepts sample_out
//   fifo_full   FIFO holds DEPTH entries
//   level       FIFO occupancy
//   sat_count   saturated samples written to the FIFO (sticky at 0xFFFF)
//   drop_count  samples lost on a full FIFO (sticky at 0xFFFF)
// ============================================================================
module fir_out_requant #(
    parameter int SHIFT  = 8,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic signed [31:0]         y_in,
    input  logic                       y_valid,
    output logic signed [15:0]         sample_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                sat_count,
    output logic [15:0]                drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE > 1) ? SW'(SETTLE - 1) : '0;

`ifdef FIR_REQ_ROUND_EN
    localparam logic signed [32:0] RND33 = 33'(1) << (SHIFT - 1);
`else
    localparam logic signed [32:0] RND33 = '0;
`endif

    // 33-bit add keeps the rounding offset from overflowing at the int32 top.
    function automatic logic signed [32:0] round_shift(input logic signed [31:0] y);
        logic signed [32:0] t;
        t = {y[31], y} + RND33;
        return t >>> SHIFT;
    endfunction

    function automatic logic clamped(input logic signed [32:0] q);
        return (q > 33'sd32767) || (q < -33'sd32768);
    endfunction

    function automatic logic signed [15:0] saturate(input logic signed [32:0] q);
        if (q > 33'sd32767)
            return 16'sh7FFF;
        else if (q < -33'sd32768)
            return 16'sh8000;
        else
            return q[15:0];
    endfunction

    // ---- mode tracking / settle window -------------------------------------
    logic          mode_q;
    logic [SW-1:0] settle_cnt;
    logic          change;
    logic          discard;

    assign change  = (mode != mode_q);
    // The change cycle itself discards, so the counter only needs SETTLE-1.
    assign discard = (SETTLE != 0) && (change || (settle_cnt != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= mode;   // no spurious settle when reset releases
            settle_cnt <= '0;
        end else if (change) begin
            mode_q     <= mode;
            settle_cnt <= SETTLE_LOAD;
        end else if (y_valid && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // ---- stage p0: requantize (combinational) ------------------------------
    logic signed [32:0] q_p0;
    logic signed [15:0] data_p0;
    logic               sat_p0;

    assign q_p0    = round_shift(y_in);
    assign data_p0 = saturate(q_p0);
    assign sat_p0  = clamped(q_p0);

    // ---- stage p1: requant register ----------------------------------------
    logic signed [15:0] data_p1;
    logic               sat_p1;
    logic               vld_p1;

    always_ff @(posedge clk) begin
        data_p1 <= data_p0;
        sat_p1  <= sat_p0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= y_valid && !discard;
    end

    // ---- stage p2: FIFO -----------------------------------------------------
    logic signed [15:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [LW-1:0]      count;
    logic signed [15:0] last_q;
    logic               full;
    logic               rd_en;
    logic               wr_en;
    logic               drop;

    assign full  = (count == LW'(DEPTH));
    assign rd_en = out_valid && out_ready;
    // A full FIFO still accepts a write when a read frees a slot this cycle.
    assign wr_en = vld_p1 && (!full || rd_en);
    assign drop  = vld_p1 && full && !rd_en;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= data_p1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_q     <= '0;
            sat_count  <= '0;
            drop_count <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && sat_p1 && (sat_count != 16'hFFFF))
                sat_count <= sat_count + 16'd1;
            if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

    assign out_valid  = (count != '0);
    assign fifo_full  = full;
    assign level      = count;
    // last_q keeps the head value visible once the FIFO drains.
    assign sample_out = out_valid ? mem[rd_ptr] : last_q;

endmodule
